instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/if_id_reg.sv | 36 +++
 rtl/instruction_fetch.sv | 78 +++++++
 tb/tb_instruction_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: NOP encoding, FSM states,
// reset PC default and PC increment.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h54000000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;
  localparam int          PC_INCR          = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load; neither means hold.
module if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [0:SIZE-1] instr_in,
  input  logic [0:SIZE-1] next_pc_in,
  output logic [0:SIZE-1] instr,
  output logic [0:SIZE-1] next_pc,
  output logic            valid
);

  localparam logic [0:SIZE-1] BUBBLE_INSTR = SIZE'(NOP_INSTR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr   <= BUBBLE_INSTR;
      next_pc <= '0;
      valid   <= 1'b0;
    end else if (bubble) begin
      instr   <= BUBBLE_INSTR;
      next_pc <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instr_in;
      next_pc <= next_pc_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register with BOOT/RUN control feeding the IF/ID
// register. imem_addr is the PC itself, so a fetch is issued the cycle the PC changes.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              SIZE     = 32,
  parameter logic [0:SIZE-1] RESET_PC = SIZE'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [0:SIZE-1] redirect_pc,
  input  logic            imem_ready,
  input  logic [0:SIZE-1] imem_data,
  output logic [0:SIZE-1] imem_addr,
  output logic [0:SIZE-1] nextPC_out,
  output logic [0:SIZE-1] instruction_out,
  output logic            valid_out,
  output logic            fsm_state
);

  localparam logic [0:SIZE-1] ALIGN_MASK = ~SIZE'(3);

  fetch_state_t    state;
  logic [0:SIZE-1] pc;
  logic [0:SIZE-1] pc_plus4;
  logic            load;
  logic            bubble;

  // Wraps modulo 2^SIZE by construction of the SIZE-bit add.
  assign pc_plus4  = pc + SIZE'(PC_INCR);
  assign imem_addr = pc;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC & ALIGN_MASK;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect)        pc <= redirect_pc & ALIGN_MASK;
          else if (stall)      pc <= pc;
          else if (imem_ready) pc <= pc_plus4;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Redirect beats stall beats a missing memory response.
  always_comb begin
    load   = 1'b0;
    bubble = 1'b0;
    if (state == BOOT)    bubble = 1'b1;
    else if (redirect)    bubble = 1'b1;
    else if (stall)       bubble = 1'b0;
    else if (!imem_ready) bubble = 1'b1;
    else                  load   = 1'b1;
  end

  if_id_reg #(
    .SIZE(SIZE)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .bubble    (bubble),
    .instr_in  (imem_data),
    .next_pc_in(pc_plus4),
    .instr     (instruction_out),
    .next_pc   (nextPC_out),
    .valid     (valid_out)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against
// a cycle-level reference model of the fetch rules.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [0:31] redirect_pc;
  logic        imem_ready;
  logic [0:31] imem_data;
  logic [0:31] imem_addr;
  logic [0:31] nextPC_out;
  logic [0:31] instruction_out;
  logic        valid_out;
  logic        fsm_state;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h54000000;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  logic        m_valid;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_ready     (imem_ready),
    .imem_data      (imem_data),
    .imem_addr      (imem_addr),
    .nextPC_out     (nextPC_out),
    .instruction_out(instruction_out),
    .valid_out      (valid_out),
    .fsm_state      (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_pc    = 32'h0;
    m_instr = NOP;
    m_npc   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = NOP;
    m_npc   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic rd, input logic [31:0] rpc,
                            input logic rdy, input logic [31:0] d);
    if (!m_run) begin
      m_run = 1'b1;
      model_bubble();
    end else if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      model_bubble();
    end else if (s) begin
      // everything holds
    end else if (!rdy) begin
      model_bubble();
    end else begin
      m_instr = d;
      m_npc   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".instr"}, instruction_out, m_instr);
    check({tag, ".npc"}, nextPC_out, m_npc);
    check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, m_valid});
    check({tag, ".addr"}, imem_addr, m_pc);
  endtask

  // Drive one cycle's inputs, check the combinational address, clock, check outputs.
  task automatic cycle(input string tag, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] d);
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_data   = d;
    #1 check({tag, ".pre_addr"}, imem_addr, m_pc);
    @(posedge clk);
    model_edge(s, rd, rpc, rdy, d);
    #1 check_outputs(tag);
  endtask

  task automatic fetch(input string tag, input logic [31:0] d);
    cycle(tag, 1'b0, 1'b0, 32'h0, 1'b1, d);
  endtask

  initial begin
    logic [31:0] a, b, c;
    a = 32'hA000_0001;
    b = 32'hB000_0002;
    c = 32'hC000_0003;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    check("reset.state", {31'b0, fsm_state}, 32'h0);
    reset = 1'b1;

    // Boot edge, then A,B,C streaming from address 0
    fetch("boot", 32'hDEAD_BEEF);
    check("boot.state", {31'b0, fsm_state}, 32'h1);
    fetch("seqA", a);
    check("seqA.instr_const", instruction_out, a);
    check("seqA.npc_const", nextPC_out, 32'h4);
    fetch("seqB", b);
    // Two stalled cycles with B held in IF/ID
    cycle("stall1", 1'b1, 1'b0, 32'h0, 1'b1, c);
    cycle("stall2", 1'b1, 1'b0, 32'h0, 1'b1, c);
    check("stall.instr_const", instruction_out, b);
    check("stall.addr_const", imem_addr, 32'h8);
    fetch("seqC", c);

    // Redirect wins over stall; low address bits dropped
    cycle("rd_stall", 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    check("rd_stall.addr_const", imem_addr, 32'h100);
    check("rd_stall.valid_const", {31'b0, valid_out}, 32'h0);
    fetch("after_rd", 32'h1111_2222);

    // Memory not ready for three cycles at 0x20
    cycle("to20", 1'b0, 1'b1, 32'h20, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle("nordy", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
      check("nordy.addr_const", imem_addr, 32'h20);
      check("nordy.instr_const", instruction_out, NOP);
    end
    fetch("rdy20", 32'h2020_2020);

    // Redirect while not ready abandons the pending fetch
    cycle("rd_nordy", 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    check("rd_nordy.addr_const", imem_addr, 32'h40);

    // Wrap at the top of the address space
    cycle("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    fetch("wrap", 32'h3333_4444);
    check("wrap.npc_const", nextPC_out, 32'h0);
    check("wrap.addr_const", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), $urandom,
            ($urandom_range(0, 3) != 0), $urandom);
    end

    // Asynchronous reset between edges, mid-stream
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    check("async_rst.state", {31'b0, fsm_state}, 32'h0);
    #1 reset = 1'b1;
    // Inputs are ignored on the boot edge
    cycle("boot2", 1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
    check("boot2.addr_const", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) fetch("restart", $urandom);
    for (int i = 0; i < 200; i++) begin
      cycle("rand2", ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 2) != 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
